// File: rtl/instr_encoder_if.sv
// Field-bundle input and packed-instruction output of the RV32 instruction packer.
// The master side produces field bundles and consumes packed words.
// The slave side (the packer) consumes bundles and produces packed words.
interface instr_encoder_if;
    logic               in_valid_i;
    logic               in_ready_o;
    logic [6:0]         opcode_i;
    logic [4:0]         rd_i;
    logic [4:0]         rs1_i;
    logic [4:0]         rs2_i;
    logic [2:0]         funct3_i;
    logic [6:0]         funct7_i;
    logic signed [31:0] imm_i;
    logic               out_valid_o;
    logic               out_ready_i;
    logic [31:0]        instr_o;
    logic [31:0]        addr_o;
    logic               err_o;
    logic [7:0]         err_cnt_o;

    modport master (
        output in_valid_i, opcode_i, rd_i, rs1_i, rs2_i, funct3_i, funct7_i, imm_i, out_ready_i,
        input  in_ready_o, out_valid_o, instr_o, addr_o, err_o, err_cnt_o
    );

    modport slave (
        input  in_valid_i, opcode_i, rd_i, rs1_i, rs2_i, funct3_i, funct7_i, imm_i, out_ready_i,
        output in_ready_o, out_valid_o, instr_o, addr_o, err_o, err_cnt_o
    );
endinterface

// File: rtl/instr_encoder.sv
// Streaming RV32 instruction packer: range-checks the immediate, packs the
// 32-bit word, tags it with a sequential byte address and queues it in a
// 2-entry FIFO. Rejected bundles are dropped and counted.
module instr_encoder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [31:0] ADDR_STEP = 32'd4
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          flush_i,
    instr_encoder_if.slave bus
);
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    // True when the immediate fits a 12-bit signed field (bits 31..11 all equal).
    function automatic logic imm_fits12(input logic signed [31:0] imm);
        return (imm[31:11] == '0) || (imm[31:11] == '1);
    endfunction

    // Saturating increment for the reject counter.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // FIFO storage and control
    logic [31:0] mem_instr_p1 [2];
    logic [31:0] mem_addr_p1  [2];
    logic        wr_ptr_p1;
    logic        rd_ptr_p1;
    logic [1:0]  count_p1;
    logic [31:0] addr_cnt_p1;
    logic        err_p1;
    logic [7:0]  err_cnt_p1;

    // ---- stage p0: combinational field packing and range check ----
    logic        vld_p0;
    logic        bad_p0;
    logic        push_p0;
    logic        pop_p0;
    logic [31:0] instr_p0;

    assign bus.in_ready_o  = (count_p1 != 2'd2);
    assign bus.out_valid_o = (count_p1 != 2'd0);
    assign bus.instr_o     = mem_instr_p1[rd_ptr_p1];
    assign bus.addr_o      = mem_addr_p1[rd_ptr_p1];
    assign bus.err_o       = err_p1;
    assign bus.err_cnt_o   = err_cnt_p1;

    assign vld_p0  = bus.in_valid_i && bus.in_ready_o;
    assign bad_p0  = (bus.opcode_i != OP_REG) && !imm_fits12(bus.imm_i);
    assign push_p0 = vld_p0 && !bad_p0;
    assign pop_p0  = bus.out_valid_o && bus.out_ready_i;

    // Select the instruction format by opcode and scatter the fields.
    always_comb begin
        instr_p0 = '0;
        case (bus.opcode_i)
            OP_STORE:  instr_p0 = {bus.imm_i[11:5], bus.rs2_i, bus.rs1_i, bus.funct3_i,
                                   bus.imm_i[4:0], bus.opcode_i};
            // Branch immediate arrives in halfword units, so imm[k] lands on offset bit k+1.
            OP_BRANCH: instr_p0 = {bus.imm_i[11], bus.imm_i[9:4], bus.rs2_i, bus.rs1_i,
                                   bus.funct3_i, bus.imm_i[3:0], bus.imm_i[10], bus.opcode_i};
            OP_REG:    instr_p0 = {bus.funct7_i, bus.rs2_i, bus.rs1_i, bus.funct3_i,
                                   bus.rd_i, bus.opcode_i};
            default:   instr_p0 = {bus.imm_i[11:0], bus.rs1_i, bus.funct3_i,
                                   bus.rd_i, bus.opcode_i};
        endcase
    end

    // ---- stage p1: FIFO write/read, address counter, reject reporting ----
    // Flush outranks push/pop; a bundle presented during flush is discarded.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            mem_instr_p1[0] <= '0;
            mem_instr_p1[1] <= '0;
            mem_addr_p1[0]  <= '0;
            mem_addr_p1[1]  <= '0;
            wr_ptr_p1       <= 1'b0;
            rd_ptr_p1       <= 1'b0;
            count_p1        <= 2'd0;
            addr_cnt_p1     <= BASE_ADDR;
            err_p1          <= 1'b0;
            err_cnt_p1      <= 8'd0;
        end else if (flush_i) begin
            wr_ptr_p1   <= 1'b0;
            rd_ptr_p1   <= 1'b0;
            count_p1    <= 2'd0;
            addr_cnt_p1 <= BASE_ADDR;
            err_p1      <= 1'b0;
            err_cnt_p1  <= 8'd0;
        end else begin
            if (push_p0) begin
                mem_instr_p1[wr_ptr_p1] <= instr_p0;
                mem_addr_p1[wr_ptr_p1]  <= addr_cnt_p1;
                wr_ptr_p1               <= ~wr_ptr_p1;
                addr_cnt_p1             <= addr_cnt_p1 + ADDR_STEP;
            end
            if (pop_p0) begin
                rd_ptr_p1 <= ~rd_ptr_p1;
            end
            case ({push_p0, pop_p0})
                2'b10:   count_p1 <= count_p1 + 2'd1;
                2'b01:   count_p1 <= count_p1 - 2'd1;
                default: count_p1 <= count_p1;
            endcase
            err_p1 <= vld_p0 && bad_p0;
            if (vld_p0 && bad_p0) begin
                err_cnt_p1 <= sat_inc8(err_cnt_p1);
            end
        end
    end
endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Streaming RV32 instruction packer; the inverse of the immediate-extraction path.
- Accepts decoded instruction fields on a valid/ready input, range-checks the immediate, packs a 32-bit instruction word, and tags it with a sequential instruction-memory byte address.
- Results drain through a 2-entry output FIFO on a valid/ready output.
- Used by the testbench/boot loader to build instruction memory images for the pipeline CPU.

Parameters:
- BASE_ADDR, 32'h0000_0000, address assigned to the first instruction after reset or flush.
- ADDR_STEP, 4, byte increment per emitted instruction.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  asynchronous, active-low reset.
- flush_i  input  1  synchronous: empties FIFO, reloads address to BASE_ADDR, clears err_cnt_o.
- in_valid_i  input  1  field bundle valid.
- in_ready_o  output  1  block can accept the bundle.
- opcode_i  input  7  instruction opcode.
- rd_i  input  5  destination register.
- rs1_i  input  5  source register 1.
- rs2_i  input  5  source register 2.
- funct3_i  input  3  funct3 field.
- funct7_i  input  7  funct7 field (R-format only).
- imm_i  input  32  signed immediate; B-format is in halfword units.
- out_valid_o  output  1  FIFO head valid.
- out_ready_i  input  1  consumer accepts head.
- instr_o  output  32  packed instruction at FIFO head.
- addr_o  output  32  byte address of instr_o.
- err_o  output  1  one-cycle pulse: bundle rejected.
- err_cnt_o  output  8  saturating count of rejected bundles.

Behaviour:
- Reset (rst_i=0, async):
  - FIFO empty; out_valid_o=0; instr_o=0; addr_o=0.
  - Address counter=BASE_ADDR; err_o=0; err_cnt_o=0.
  - in_ready_o=1 once reset is released.
- Format is selected by opcode:
  - 0100011 = S-format: instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
  - 1100011 = B-format: instr = {imm[11], imm[9:4], rs2, rs1, funct3, imm[3:0], imm[10], opcode}.
  - 0110011 = R-format: instr = {funct7, rs2, rs1, funct3, rd, opcode}; imm_i is ignored and never flagged.
  - Any other opcode = I-format: instr = {imm[11:0], rs1, funct3, rd, opcode}.
- Range check (S/I/B): imm_i[31:11] must be all 0s or all 1s (12-bit signed).
  - Failing bundle is consumed and dropped, no FIFO write, address does not advance.
  - err_o pulses high the cycle after acceptance.
  - err_cnt_o increments and saturates at 255.
- Handshakes:
  - Input transfer occurs when in_valid_i & in_ready_o at a clock edge.
  - in_ready_o = FIFO not full, combinational from registered count only; it never depends on in_valid_i.
  - Output transfer occurs when out_valid_o & out_ready_i.
  - out_valid_o = FIFO not empty; instr_o/addr_o are driven from the head register.
  - out_valid_o/instr_o/addr_o must stay stable while out_valid_o & !out_ready_i.
- Latency: a bundle accepted at edge N appears at the head no earlier than after edge N; it is visible in the cycle following N when the FIFO was empty.
- Throughput: 1 instruction/cycle sustained when out_ready_i=1.
- Address: the counter value is captured with each valid bundle on push, then increments by ADDR_STEP; wraps modulo 2^32.
- FIFO (2 entries, circular, 1-bit pointers, 2-bit count):
  - Push+pop in the same cycle leaves the count unchanged and keeps ordering.
  - When full, in_ready_o=0, so no push can occur.
  - A pop while empty is impossible by construction.
- flush_i has priority over push/pop in the same cycle; a concurrent input bundle is discarded.
- Reset mid-stream: all in-flight entries are lost and the address restarts at BASE_ADDR.

Test Plan:
- addi x1,x0,5 (opcode 0010011, rd=1, funct3=0, imm=5), out_ready_i=1 -> instr_o=0x00500093, addr_o=0x0, out_valid_o one cycle after acceptance.
- Stream in order:
  - sw x2,8(x1) (rs1=1, rs2=2, funct3=010, imm=8) -> 0x0020A423 at addr 0x4.
  - beq x1,x2 with imm=-2 -> 0xFE208EE3 at addr 0x8.
  - add x3,x1,x2 (funct7=0) -> 0x002081B3 at addr 0xC.
- addi with imm=2048 -> no output, err_o pulse, err_cnt_o=1; next valid bundle takes the un-advanced address.
- Hold out_ready_i=0, present 3 bundles back-to-back:
  - in_ready_o drops after 2 accepts; head is held stable.
  - Release out_ready_i -> all 3 emerge in order with consecutive addresses.
- Assert rst_i low with 2 entries queued -> out_valid_o=0 immediately; after release the next instruction is at addr BASE_ADDR.
- flush_i together with a push and a pop -> FIFO empty, address=BASE_ADDR, err_cnt_o=0.
